keccak_padder: RTL and testbench

KECCAK_PADDER -- requirements
Module: keccak_padder

---
 rtl/keccak_padder_pkg.sv | 26 ++
 rtl/keccak_padder_pad_word.sv | 31 +++
 rtl/keccak_padder.sv | 160 ++++++++++++++++
 tb/tb_keccak_padder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_padder_pkg.sv
// Shared constants and state type for the Keccak padder.
// Optional build macro: KECCAK_PADDER_SHA3_EN selects the SHA-3 domain
// suffix (0x06) as the first pad byte instead of Keccak pad10*1 (0x01).
package pkg_keccak;

  localparam int unsigned IN_BUF_SIZE = 64;
  localparam int unsigned RATE_WORDS  = 16;

  // Index of the last 64-bit word of a rate block
  localparam logic [3:0] LAST_WCNT = 4'(RATE_WORDS - 1);

`ifdef KECCAK_PADDER_SHA3_EN
  localparam logic [7:0] PAD_FIRST_BYTE = 8'h06;
`else
  localparam logic [7:0] PAD_FIRST_BYTE = 8'h01;
`endif
  localparam logic [7:0] PAD_LAST_BYTE  = 8'h80;

  typedef enum logic [1:0] {
    DATA      = 2'd0,
    PAD       = 2'd1,
    WAIT_FULL = 2'd2,
    WAIT_DONE = 2'd3
  } padder_state_t;

endpackage

// File: rtl/keccak_padder_pad_word.sv
// Combinational pad insertion for one 64-bit word.
// first: keep bytes below nbytes, put the first pad byte at nbytes, zero above.
// last : OR the final pad byte into bits [63:56].
import pkg_keccak::*;

module keccak_pad_word (
  input  logic [IN_BUF_SIZE-1:0] word,
  input  logic [3:0]             nbytes,
  input  logic                   first,
  input  logic                   last,
  output logic [IN_BUF_SIZE-1:0] padded
);

  // Byte-wise masking and pad byte placement
  always_comb begin
    padded = word;
    if (first) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (k > 32'(nbytes)) begin
          padded[8*k +: 8] = '0;
        end else if (k == 32'(nbytes)) begin
          padded[8*k +: 8] = PAD_FIRST_BYTE;
        end
      end
    end
    if (last) begin
      padded[63:56] = padded[63:56] | PAD_LAST_BYTE;
    end
  end

endmodule

// File: rtl/keccak_padder.sv
// Keccak message padder: passes message words to the permutation input with
// zero latency and appends pad10*1 (or SHA-3 suffix with KECCAK_PADDER_SHA3_EN),
// filling the rest of the 16-word rate block.
import pkg_keccak::*;

module keccak_padder (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [IN_BUF_SIZE-1:0] In_data,
  input  logic [3:0]             In_bytes,
  input  logic                   In_valid,
  input  logic                   In_last,
  output logic                   In_ready,
  output logic [IN_BUF_SIZE-1:0] Din,
  output logic                   Din_valid,
  output logic                   Last_block,
  input  logic                   Buffer_full,
  input  logic                   Ready,
  output logic                   Busy
);

  padder_state_t state, state_n;
  logic [3:0]    wcnt, wcnt_n;
  logic          pad_pend, pad_pend_n;   // 0x01 pad byte still owed to a PAD word
  logic          msg_last, msg_last_n;   // final message word has been taken
  logic          active, active_n;       // a message has started

  logic                   short_last;
  logic                   emit;
  logic [IN_BUF_SIZE-1:0] pw_word;
  logic [3:0]             pw_nbytes;
  logic                   pw_first;
  logic                   pw_last;
  logic [IN_BUF_SIZE-1:0] padded;

  assign short_last = In_last && (In_bytes < 4'd8);

  // Select what goes through the pad inserter: message data in DATA, a
  // synthetic zero word in PAD
  always_comb begin
    pw_word   = '0;
    pw_nbytes = '0;
    pw_first  = 1'b0;
    pw_last   = 1'b0;
    if (state == DATA) begin
      pw_word   = In_data;
      pw_nbytes = short_last ? In_bytes : 4'd8;
      pw_first  = short_last;
      pw_last   = short_last && (wcnt == LAST_WCNT);
    end else begin
      pw_first  = pad_pend;
      pw_last   = (wcnt == LAST_WCNT);
    end
  end

  keccak_pad_word u_pad_word (
    .word   (pw_word),
    .nbytes (pw_nbytes),
    .first  (pw_first),
    .last   (pw_last),
    .padded (padded)
  );

  // State register; Start and Reset both return to an empty idle
  always_ff @(posedge Clock) begin
    if (!Reset || Start) begin
      state    <= DATA;
      wcnt     <= '0;
      pad_pend <= 1'b0;
      msg_last <= 1'b0;
      active   <= 1'b0;
    end else begin
      state    <= state_n;
      wcnt     <= wcnt_n;
      pad_pend <= pad_pend_n;
      msg_last <= msg_last_n;
      active   <= active_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n    = state;
    wcnt_n     = wcnt;
    pad_pend_n = pad_pend;
    msg_last_n = msg_last;
    active_n   = active;
    if (emit) begin
      wcnt_n   = wcnt + 4'd1;
      active_n = 1'b1;
    end
    case (state)
      DATA: begin
        if (emit) begin
          if (In_last) begin
            msg_last_n = 1'b1;
            pad_pend_n = !short_last;
          end
          if (wcnt == LAST_WCNT) begin
            state_n = WAIT_FULL;
          end else if (In_last) begin
            state_n = PAD;
          end
        end
      end
      PAD: begin
        if (emit) begin
          pad_pend_n = 1'b0;
          if (wcnt == LAST_WCNT) begin
            state_n = WAIT_FULL;
          end
        end
      end
      WAIT_FULL: begin
        // A full-length final word leaves the pad byte owed, so one more
        // (pad-only) block follows before the message is complete
        if (Buffer_full) begin
          if (msg_last && !pad_pend) begin
            state_n = WAIT_DONE;
          end else if (pad_pend) begin
            state_n = PAD;
          end else begin
            state_n = DATA;
          end
        end
      end
      WAIT_DONE: begin
        if (!Buffer_full && Ready) begin
          state_n    = DATA;
          msg_last_n = 1'b0;
          active_n   = 1'b0;
        end
      end
      default: state_n = DATA;
    endcase
  end

  // Output logic: handshakes and the padded word are combinational
  always_comb begin
    In_ready = 1'b0;
    emit     = 1'b0;
    if (Reset && !Start) begin
      case (state)
        DATA: begin
          In_ready = !Buffer_full;
          emit     = In_valid && !Buffer_full;
        end
        PAD:     emit = !Buffer_full;
        default: emit = 1'b0;
      endcase
    end
    Din_valid  = emit;
    Din        = emit ? padded : '0;
    Last_block = emit && pw_last;
    Busy       = Reset && (active || (state != DATA)) &&
                 !((state == WAIT_DONE) && !Buffer_full && Ready);
  end

endmodule

// File: tb/tb_keccak_padder.sv
// Scoreboard bench for keccak_padder: stimulus pushes hand-computed words,
// a monitor pops and compares whenever Din_valid is seen.
module tb_keccak_padder;

`ifdef KECCAK_PADDER_SHA3_EN
  localparam logic [7:0] P1 = 8'h06;
`else
  localparam logic [7:0] P1 = 8'h01;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] in_data = '0;
  logic [3:0]  in_bytes = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [63:0] din;
  logic        din_valid;
  logic        last_block;
  logic        buffer_full;
  logic        ready;
  logic        busy;
  logic        auto_full = 1'b0;
  logic        force_full = 1'b0;

  assign buffer_full = auto_full | force_full;
  assign ready       = !auto_full;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   bcnt = 0;

  always #5 clk = ~clk;

  keccak_padder dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .Start       (start),
    .In_data     (in_data),
    .In_bytes    (in_bytes),
    .In_valid    (in_valid),
    .In_last     (in_last),
    .In_ready    (in_ready),
    .Din         (din),
    .Din_valid   (din_valid),
    .Last_block  (last_block),
    .Buffer_full (buffer_full),
    .Ready       (ready),
    .Busy        (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    sb.push_back(e);
  endtask

  // Push zero words up to word 14 and the 0x80 closing word with Last_block
  task automatic push_tail(input int from);
    for (int i = from; i < 15; i++) push(64'h0, 1'b0);
    push(64'h8000000000000000, 1'b1);
  endtask

  // Present one word and wait (bounded) for acceptance; returns at posedge+1
  task automatic send(input logic [63:0] d, input logic [3:0] nb, input logic l);
    in_data  = d;
    in_bytes = nb;
    in_last  = l;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout actual=no_in_ready required=in_ready");
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        check({name, "_busy_idle"}, 64'(busy), 64'h0);
        @(posedge clk);
        #1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s_timeout actual=pending=%0d busy=%0b required=pending=0 busy=0",
             name, sb.size(), busy);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  // Keccak core model: after 16 accepted words hold Buffer_full (Ready low)
  // for 4 cycles to mimic absorption
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || start) begin
        bcnt = 0;
      end else if (din_valid) begin
        bcnt++;
        if (bcnt == 16) begin
          bcnt = 0;
          @(posedge clk);
          #1 auto_full = 1'b1;
          repeat (4) @(posedge clk);
          #1 auto_full = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (buffer_full) check("valid_while_full", 64'(din_valid), 64'h0);
      if (din_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word actual=%h required=no_word", din);
        end else begin
          e = sb.pop_front();
          check("din", din, e.d);
          check("last_block", 64'(last_block), 64'(e.l));
        end
      end else if (last_block) begin
        check("last_without_valid", 64'(last_block), 64'h0);
      end
    end
  end

  initial begin
    #400000;
    total++;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // Reset state, with a word presented to show it is ignored
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 64'h1122334455667788;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_din_valid", 64'(din_valid), 64'h0);
    check("rst_din", din, 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'h0);
    check("post_rst_in_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;

    // Empty message; upper garbage must be zeroed
    push({56'h0, P1}, 1'b0);
    push_tail(1);
    send(64'hDEADBEEFCAFEF00D, 4'd0, 1'b1);
    @(negedge clk);
    check("empty_busy", 64'(busy), 64'h1);
    @(posedge clk);
    #1;
    wait_idle("empty");

    // "abc"
    push({32'h0, P1, 24'h636261}, 1'b0);
    push_tail(1);
    send(64'hAAAAAAAAAA636261, 4'd3, 1'b1);
    wait_idle("abc");

    // 127 bytes: 15 full words, then 7 bytes -> 0x81 in byte 7
    for (int i = 0; i < 15; i++) begin
      logic [63:0] w;
      w = 64'h0101010101010101 * 64'(i + 1);
      push(w, 1'b0);
      send(w, 4'd8, 1'b0);
    end
    push({P1 | 8'h80, 56'hEEDDCCBBAA9988}, 1'b1);
    send(64'hFFEEDDCCBBAA9988, 4'd7, 1'b1);
    wait_idle("m127");

    // 128 bytes: unchanged block, then pad-only block
    for (int i = 0; i < 16; i++) begin
      logic [63:0] w;
      w = 64'h0F0E0D0C0B0A0908 + 64'(i);
      push(w, 1'b0);
      send(w, 4'd8, (i == 15));
    end
    push({56'h0, P1}, 1'b0);
    push_tail(1);
    wait_idle("m128");

    // Stall at word 7 for 10 cycles
    for (int i = 0; i < 7; i++) begin
      logic [63:0] w;
      w = 64'h7000000000000000 + 64'(i);
      push(w, 1'b0);
      send(w, 4'd8, 1'b0);
    end
    force_full = 1'b1;
    in_data    = 64'h123456789ABCDEF0;
    in_bytes   = 4'd2;
    in_last    = 1'b1;
    in_valid   = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'h0);
      check("stall_din_valid", 64'(din_valid), 64'h0);
    end
    @(posedge clk);
    #1;
    force_full = 1'b0;
    push({40'h0, P1, 16'hDEF0}, 1'b0);
    push_tail(8);
    send(64'h123456789ABCDEF0, 4'd2, 1'b1);
    wait_idle("stall");

    // Start at wcnt = 5 with a word presented: nothing more may be emitted
    for (int i = 0; i < 5; i++) begin
      logic [63:0] w;
      w = 64'h5500000000000000 + 64'(i);
      push(w, 1'b0);
      send(w, 4'd8, 1'b0);
    end
    start    = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_bytes = 4'd3;
    @(negedge clk);
    check("start_din_valid", 64'(din_valid), 64'h0);
    check("start_in_ready", 64'(in_ready), 64'h0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("after_start_busy", 64'(busy), 64'h0);
    check("after_start_pending", 64'(sb.size()), 64'h0);
    @(posedge clk);
    #1;
    push({32'h0, P1, 24'h636261}, 1'b0);
    push_tail(1);
    send(64'h0000000000636261, 4'd3, 1'b1);
    wait_idle("restart_abc");

    // Reset mid-message discards the rest
    for (int i = 0; i < 3; i++) begin
      logic [63:0] w;
      w = 64'h3300000000000000 + 64'(i);
      push(w, 1'b0);
      send(w, 4'd8, 1'b0);
    end
    rst_n    = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("midrst_din_valid", 64'(din_valid), 64'h0);
    check("midrst_in_ready", 64'(in_ready), 64'h0);
    check("midrst_last", 64'(last_block), 64'h0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'h0);
    @(posedge clk);
    #1;
    push({56'h0, P1}, 1'b0);
    push_tail(1);
    send(64'h0, 4'd0, 1'b1);
    wait_idle("after_midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
